// File: rtl/rx_bit_packer.sv
// Packs the demodulated bit stream LSB-first into 32-bit AXI4-Stream words, buffered by a 2-entry output buffer.
// Optional partial-word flush on idle timeout is enabled by defining PACKER_TIMEOUT_EN.
module rx_bit_packer #(
  parameter int WORDS_PER_PKT  = 64,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        adc_dco_clk,
  input  logic        rst,
  input  logic        bit_valid,
  input  logic        bit_data,
  output logic [31:0] m_axis_tdata,
  output logic [3:0]  m_axis_tkeep,
  output logic        m_axis_tlast,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        overrun,
  output logic [15:0] drop_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_t;

  typedef struct packed {
    logic [31:0] dat;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  localparam logic [15:0] LAST_IDX = 16'(WORDS_PER_PKT - 1);

  logic [31:0] shreg;
  logic [5:0]  bit_cnt;
  logic [15:0] word_cnt;
  occ_t        occ;
  beat_t       head;
  beat_t       tail;
  beat_t       new_beat;

  logic full_bit;
  logic flush;
  logic complete;
  logic hs;
  logic drop;
  logic push;

  assign full_bit = bit_valid && (bit_cnt == 6'd31);
  assign complete = full_bit || flush;
  assign hs       = m_axis_tvalid && m_axis_tready;
  assign drop     = complete && (occ == TWO) && !hs;
  assign push     = complete && !drop;

`ifdef PACKER_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYCLES);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);

  logic [IW-1:0] idle_cnt;
  logic [3:0]    flush_keep;

  // A bit arriving in the timeout cycle wins: the flush is suppressed and the bit packs normally.
  assign flush = !bit_valid && (bit_cnt != 6'd0) && (idle_cnt == IDLE_LAST);

  always_ff @(posedge adc_dco_clk) begin
    if (rst || bit_valid || bit_cnt == 6'd0 || flush) idle_cnt <= '0;
    else                                             idle_cnt <= idle_cnt + 1'b1;
  end

  always_comb begin
    flush_keep = 4'hF;
    if (bit_cnt <= 6'd8)       flush_keep = 4'h1;
    else if (bit_cnt <= 6'd16) flush_keep = 4'h3;
    else if (bit_cnt <= 6'd24) flush_keep = 4'h7;
  end

  always_comb begin
    new_beat.dat  = full_bit ? {bit_data, shreg[30:0]} : shreg;
    new_beat.keep = flush ? flush_keep : 4'hF;
    new_beat.last = flush || (word_cnt == LAST_IDX);
  end
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;

  assign flush = 1'b0;

  always_comb begin
    new_beat.dat  = {bit_data, shreg[30:0]};
    new_beat.keep = 4'hF;
    new_beat.last = (word_cnt == LAST_IDX);
  end
`endif

  // Shift register is cleared on every completion so a flushed word has zeroed unfilled bits.
  always_ff @(posedge adc_dco_clk) begin
    if (rst) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      word_cnt <= '0;
      overrun  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (bit_valid) begin
        if (full_bit) begin
          shreg   <= '0;
          bit_cnt <= '0;
        end else begin
          shreg[bit_cnt[4:0]] <= bit_data;
          bit_cnt             <= bit_cnt + 6'd1;
        end
      end else if (flush) begin
        shreg   <= '0;
        bit_cnt <= '0;
      end
      if (push) word_cnt <= new_beat.last ? 16'd0 : word_cnt + 16'd1;
      if (drop) begin
        overrun <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  // Output buffer: head is always the beat on the bus; tail holds the second word.
  always_ff @(posedge adc_dco_clk) begin
    if (rst) begin
      occ           <= EMPTY;
      head          <= '0;
      tail          <= '0;
      m_axis_tvalid <= 1'b0;
    end else begin
      case (occ)
        EMPTY: begin
          if (push) begin
            head          <= new_beat;
            occ           <= ONE;
            m_axis_tvalid <= 1'b1;
          end
        end
        ONE: begin
          if (hs && push) begin
            head <= new_beat;
          end else if (hs) begin
            occ           <= EMPTY;
            m_axis_tvalid <= 1'b0;
          end else if (push) begin
            tail <= new_beat;
            occ  <= TWO;
          end
        end
        TWO: begin
          if (hs) begin
            head <= tail;
            if (push) tail <= new_beat;
            else      occ  <= ONE;
          end
        end
        default: begin
          occ           <= EMPTY;
          m_axis_tvalid <= 1'b0;
        end
      endcase
    end
  end

  assign m_axis_tdata = head.dat;
  assign m_axis_tkeep = head.keep;
  assign m_axis_tlast = head.last;

endmodule

// File: tb/tb_rx_bit_packer.sv
// Directed bench for rx_bit_packer (WORDS_PER_PKT=4, TIMEOUT_CYCLES=16); beats captured on handshake.
module tb_rx_bit_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        bit_valid;
  logic        bit_data;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast;
  logic        tvalid;
  logic        tready;
  logic        overrun;
  logic [15:0] drop_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int base  = 0;

  logic [36:0] beats[$];

  always #5 clk = ~clk;

  rx_bit_packer #(.WORDS_PER_PKT(4), .TIMEOUT_CYCLES(16)) dut (
    .adc_dco_clk   (clk),
    .rst           (rst),
    .bit_valid     (bit_valid),
    .bit_data      (bit_data),
    .m_axis_tdata  (tdata),
    .m_axis_tkeep  (tkeep),
    .m_axis_tlast  (tlast),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .overrun       (overrun),
    .drop_cnt      (drop_cnt)
  );

  always @(posedge clk) begin
    if (!rst && tvalid && tready) beats.push_back({tlast, tkeep, tdata});
  end

  task automatic check(input string tag, input logic [36:0] got, input logic [36:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [36:0] beat_at(input int i);
    if (base + i < beats.size()) return beats[base + i];
    return 'x;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bit_valid = 1'b1;
    bit_data  = b;
    tick(1);
    bit_valid = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) send_bit(w[i]);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick(1);
    rst  = 1'b0;
    base = beats.size();
  endtask

  initial begin
    rst = 1'b1; bit_valid = 1'b0; bit_data = 1'b0; tready = 1'b0;
    tick(2);
    do_reset();
    check("rst_tvalid", 37'(tvalid), 37'd0);
    check("rst_tdata", 37'(tdata), 37'd0);
    check("rst_flags", {20'd0, overrun, drop_cnt}, 37'd0);

    // 1: alternating bits -> 5555_5555, tvalid the cycle after the 32nd bit
    tready = 1'b1;
    send_bits(32'h5555_5555, 31);
    check("t1_tvalid_early", 37'(tvalid), 37'd0);
    send_bits(32'h0000_0000, 1);
    check("t1_tvalid", 37'(tvalid), 37'd1);
    check("t1_head", {tlast, tkeep, tdata}, {1'b0, 4'hF, 32'h5555_5555});
    tick(1);
    check("t1_beats", 37'(beats.size() - base), 37'd1);

    // 2: tlast on the 4th word only, 5th starts a new packet
    do_reset();
    tready = 1'b1;
    send_bits(32'h0000_0001, 32);
    send_bits(32'h8000_0000, 32);
    send_bits(32'hA5A5_0F0F, 32);
    send_bits(32'h1234_5678, 32);
    send_bits(32'hDEAD_BEEF, 32);
    tick(2);
    check("t2_beats", 37'(beats.size() - base), 37'd5);
    check("t2_w0", beat_at(0), {1'b0, 4'hF, 32'h0000_0001});
    check("t2_w1", beat_at(1), {1'b0, 4'hF, 32'h8000_0000});
    check("t2_w2", beat_at(2), {1'b0, 4'hF, 32'hA5A5_0F0F});
    check("t2_w3_last", beat_at(3), {1'b1, 4'hF, 32'h1234_5678});
    check("t2_w4", beat_at(4), {1'b0, 4'hF, 32'hDEAD_BEEF});

    // 3: third word dropped while buffer full, then drain in order
    do_reset();
    tready = 1'b0;
    send_bits(32'h1111_1111, 32);
    send_bits(32'h2222_2222, 32);
    send_bits(32'h3333_3333, 32);
    check("t3_overrun", 37'(overrun), 37'd1);
    check("t3_drop_cnt", 37'(drop_cnt), 37'd1);
    check("t3_hold", {tlast, tkeep, tdata}, {1'b0, 4'hF, 32'h1111_1111});
    tready = 1'b1;
    tick(4);
    check("t3_beats", 37'(beats.size() - base), 37'd2);
    check("t3_w0", beat_at(0), {1'b0, 4'hF, 32'h1111_1111});
    check("t3_w1", beat_at(1), {1'b0, 4'hF, 32'h2222_2222});
    check("t3_idle", 37'(tvalid), 37'd0);
    check("t3_sticky", {20'd0, overrun, drop_cnt}, {20'd0, 1'b1, 16'd1});

    // 4: completion coincides with handshake while full -> no drop
    do_reset();
    tready = 1'b0;
    send_bits(32'h1111_1111, 32);
    send_bits(32'h2222_2222, 32);
    send_bits(32'h7777_7777, 31);
    tready = 1'b1;
    send_bits(32'h0000_0000, 1);
    tick(4);
    check("t4_drop_cnt", 37'(drop_cnt), 37'd0);
    check("t4_overrun", 37'(overrun), 37'd0);
    check("t4_beats", 37'(beats.size() - base), 37'd3);
    check("t4_w2", beat_at(2), {1'b0, 4'hF, 32'h7777_7777});

    // 5: 12 ones then idle
    do_reset();
    tready = 1'b1;
    send_bits(32'hFFFF_FFFF, 12);
`ifdef PACKER_TIMEOUT_EN
    tick(15);
    check("t5_no_flush_yet", 37'(tvalid), 37'd0);
    tick(1);
    check("t5_flush_vld", 37'(tvalid), 37'd1);
    check("t5_flush_beat", {tlast, tkeep, tdata}, {1'b1, 4'h3, 32'h0000_0FFF});
    tick(1);
    check("t5_beats", 37'(beats.size() - base), 37'd1);
`else
    tick(200);
    check("t5_no_flush", 37'(beats.size() - base), 37'd0);
    send_bits(32'h0000_0000, 20);
    tick(2);
    check("t5_held_beat", beat_at(0), {1'b0, 4'hF, 32'h0000_0FFF});
`endif

    // 6: reset mid-packet discards everything
    do_reset();
    tready = 1'b0;
    send_bits(32'h1111_1111, 32);
    send_bits(32'h2222_2222, 32);
    send_bits(32'h3333_3333, 32);
    send_bits(32'hFFFF_FFFF, 20);
    do_reset();
    check("t6_tvalid", 37'(tvalid), 37'd0);
    check("t6_flags", {20'd0, overrun, drop_cnt}, 37'd0);
    tready = 1'b1;
    send_bits(32'hCAFE_F00D, 32);
    tick(2);
    check("t6_beats", 37'(beats.size() - base), 37'd1);
    check("t6_fresh", beat_at(0), {1'b0, 4'hF, 32'hCAFE_F00D});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
